ofifo_drain_ctrl: RTL and testbench

//  Read-side controller for the per-column output FIFO. It pops row-aligned words (col x bw)

---
 rtl/ofifo_drain_ctrl_if.sv | 24 ++
 rtl/ofifo_drain_ctrl.sv | 111 +++++++++++
 tb/tb_ofifo_drain_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofifo_drain_ctrl_if.sv
// Bundles the output-FIFO read port and the psum SRAM write port seen by the drain controller.
// The master side is the controller; the slave side is the FIFO/SRAM environment.
interface ofifo_drain_ctrl_if #(
    parameter int col    = 8,
    parameter int bw     = 16,
    parameter int addr_w = 11
) ();
    logic                  ofifo_valid;
    logic [col*bw-1:0]     ofifo_out;
    logic                  ofifo_rd;
    logic                  sram_we;
    logic [addr_w-1:0]     sram_addr;
    logic [col*bw-1:0]     sram_data;

    modport master (
        input  ofifo_valid, ofifo_out,
        output ofifo_rd, sram_we, sram_addr, sram_data
    );

    modport slave (
        output ofifo_valid, ofifo_out,
        input  ofifo_rd, sram_we, sram_addr, sram_data
    );
endinterface

// File: rtl/ofifo_drain_ctrl.sv
// Drains num_words row-aligned words from the output FIFO into consecutive psum SRAM
// addresses starting at base_addr. One word per WAIT->REQ->CAPT->WR round trip, so the
// FIFO's registered pop has retired before ofifo_valid is looked at again.
module ofifo_drain_ctrl #(
    parameter int col    = 8,
    parameter int bw     = 16,
    parameter int addr_w = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [addr_w-1:0]    base_addr,
    input  logic [addr_w-1:0]    num_words,
    ofifo_drain_ctrl_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic [addr_w-1:0]    drained_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_CAPT,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [addr_w-1:0] one_w = addr_w'(1);

    state_t                state_q, state_d;
    logic [addr_w-1:0]     addr_q,  addr_d;
    logic [addr_w-1:0]     rem_q,   rem_d;
    logic [addr_w-1:0]     cnt_q,   cnt_d;
    logic [col*bw-1:0]     data_q,  data_d;

    // State and datapath registers; synchronous active-high reset returns everything to zero/IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Next-state and datapath update: latch the pass on start, capture in CAPT, advance in WR.
    always_comb begin
        // NOTE: every _d takes its hold value first so no path through the case can infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = num_words;
                    cnt_d   = '0;
                    state_d = (num_words == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.ofifo_valid) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                // The FIFO's registered read enable is active now, so its head is the popped word.
                data_d  = bus.ofifo_out;
                state_d = S_WR;
            end
            S_WR: begin
                // Address wraps naturally modulo 2^addr_w.
                addr_d  = addr_q + one_w;
                rem_d   = rem_q - one_w;
                cnt_d   = cnt_q + one_w;
                state_d = (rem_q == one_w) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs: strobes decode the state, bus values come straight from registers.
    assign bus.ofifo_rd  = (state_q == S_REQ);
    assign bus.sram_we   = (state_q == S_WR);
    assign bus.sram_addr = addr_q;
    assign bus.sram_data = data_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign drained_cnt   = cnt_q;

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Scoreboard bench for ofifo_drain_ctrl: stimulus pushes expected writes/done counts,
// a negedge monitor pops and compares whenever the DUT presents sram_we or done.
module tb_ofifo_drain_ctrl;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;
    localparam int DW  = COL * BW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_words;
    logic          busy;
    logic          done;
    logic [AW-1:0] drained_cnt;

    ofifo_drain_ctrl_if #(.col(COL), .bw(BW), .addr_w(AW)) bus ();

    ofifo_drain_ctrl #(.col(COL), .bw(BW), .addr_w(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .drained_cnt (drained_cnt)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    wr_t           exp_q[$];
    logic [AW-1:0] done_q[$];
    logic [DW-1:0] fifo_q[$];
    int            we_cyc[$];
    int            done_cyc = -1;
    int            done_seen = 0;
    int            rd_cnt = 0;
    logic          prev_rd = 1'b0;
    logic          valid_at_edge = 1'b0;
    logic          rd_r = 1'b0;
    logic          valid_en = 1'b0;
    bit            rnd_valid = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered pop, one cycle after ofifo_rd.
    always @(posedge clk) begin
        valid_at_edge <= bus.ofifo_valid;
        if (reset) begin
            fifo_q.delete();
            rd_r <= 1'b0;
        end else begin
            if (rd_r && fifo_q.size() != 0) void'(fifo_q.pop_front());
            rd_r <= bus.ofifo_rd;
        end
    end

    always @(negedge clk) begin
        bus.ofifo_valid = valid_en && (fifo_q.size() != 0);
        bus.ofifo_out   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    always @(posedge clk) begin
        if (rnd_valid) begin
            #1 valid_en = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (bus.ofifo_rd) begin
            rd_cnt++;
            check("rd_after_valid", DW'(valid_at_edge), DW'(1));
            check("rd_back_to_back", DW'(prev_rd), DW'(0));
        end
        prev_rd = bus.ofifo_rd;
        if (bus.sram_we) begin
            we_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_we_qsize", DW'(exp_q.size()), DW'(1));
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sram_addr", DW'(bus.sram_addr), DW'(e.addr));
                check("sram_data", bus.sram_data, e.data);
            end
        end
        if (done) begin
            done_cyc = cyc;
            done_seen++;
            check("busy_in_done", DW'(busy), DW'(1));
            if (done_q.size() == 0) begin
                check("unexpected_done_qsize", DW'(done_q.size()), DW'(1));
            end else begin
                logic [AW-1:0] n;
                n = done_q.pop_front();
                check("drained_cnt", DW'(drained_cnt), DW'(n));
                check("writes_left_at_done", DW'(exp_q.size()), DW'(0));
            end
        end
    end

    task automatic fill_seq(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            for (int j = 0; j < COL; j++) begin
                logic [7:0] lo;
                logic [7:0] hi;
                lo = first + 8'(i);
                hi = 8'(j);
                w[j*BW +: BW] = {hi, lo};
            end
            fifo_q.push_back(w);
        end
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns the start cycle number.
    task automatic start_pass(input logic [AW-1:0] b, input logic [AW-1:0] n, output int s);
        for (int k = 0; k < int'(n); k++) begin
            wr_t e;
            e.addr = b + k[AW-1:0];
            e.data = fifo_q[k];
            exp_q.push_back(e);
        end
        done_q.push_back(n);
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        s         = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) check("idle_timeout", DW'(busy), DW'(0));
    endtask

    task automatic case1();
        int s;
        fill_seq(4, 8'hA0);
        we_cyc.delete();
        done_cyc = -1;
        valid_en = 1'b1;
        start_pass(11'h010, 11'd4, s);
        wait_idle(100);
        check("c1_we_count", DW'(we_cyc.size()), DW'(4));
        for (int i = 0; i < 4 && i < we_cyc.size(); i++) begin
            check("c1_we_cycle", DW'(we_cyc[i] - s), DW'(4 + 4 * i));
        end
        check("c1_done_cycle", DW'(done_cyc - s), DW'(17));
        check("c1_drained", DW'(drained_cnt), DW'(4));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int s;
        int v;
        int rd0;
        int d0;
        int k;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_rd", DW'(bus.ofifo_rd), DW'(0));
        check("rst_we", DW'(bus.sram_we), DW'(0));
        check("rst_addr", DW'(bus.sram_addr), DW'(0));
        check("rst_data", bus.sram_data, DW'(0));
        check("rst_drained", DW'(drained_cnt), DW'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Case 1: basic 4-word drain with latency.
        case1();

        // Case 2: valid held low for 10 cycles.
        fill_seq(2, 8'h30);
        we_cyc.delete();
        valid_en = 1'b0;
        rd0 = rd_cnt;
        start_pass(11'h020, 11'd2, s);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("c2_no_rd_while_invalid", DW'(rd_cnt - rd0), DW'(0));
        valid_en = 1'b1;
        v = cyc;
        wait_idle(100);
        check("c2_we_count", DW'(we_cyc.size()), DW'(2));
        if (we_cyc.size() != 0) check("c2_first_we_latency", DW'(we_cyc[0] - v), DW'(3));
        check("c2_pops", DW'(rd_cnt - rd0), DW'(2));

        // Case 3: zero-length pass.
        we_cyc.delete();
        done_cyc = -1;
        rd0 = rd_cnt;
        start_pass(11'h030, 11'd0, s);
        check("c3_busy_after_start", DW'(busy), DW'(1));
        @(posedge clk);
        #1;
        check("c3_idle_again", DW'(busy), DW'(0));
        check("c3_done_cycle", DW'(done_cyc - s), DW'(1));
        check("c3_no_rd", DW'(rd_cnt - rd0), DW'(0));
        check("c3_no_we", DW'(we_cyc.size()), DW'(0));

        // Case 4: start re-pulsed while busy is ignored.
        fill_seq(3, 8'h50);
        we_cyc.delete();
        d0 = done_seen;
        start_pass(11'h100, 11'd3, s);
        repeat (3) begin
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            base_addr = AW'($urandom);
            num_words = AW'($urandom);
            start = busy;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_idle(100);
        check("c4_we_count", DW'(we_cyc.size()), DW'(3));
        check("c4_done_count", DW'(done_seen - d0), DW'(1));

        // Case 5: address wrap.
        fill_seq(3, 8'h70);
        start_pass(11'h7FE, 11'd3, s);
        wait_idle(100);
        check("c5_drained", DW'(drained_cnt), DW'(3));

        // Case 6: reset in CAPT of word 2 of 5, then case 1 again.
        fill_seq(5, 8'h90);
        rd0 = rd_cnt;
        start_pass(11'h040, 11'd5, s);
        k = 0;
        while (rd_cnt < rd0 + 2 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("c6_reached_second_pop", DW'(rd_cnt - rd0), DW'(2));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("c6_busy", DW'(busy), DW'(0));
        check("c6_done", DW'(done), DW'(0));
        check("c6_rd", DW'(bus.ofifo_rd), DW'(0));
        check("c6_we", DW'(bus.sram_we), DW'(0));
        check("c6_addr", DW'(bus.sram_addr), DW'(0));
        check("c6_drained", DW'(drained_cnt), DW'(0));
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        case1();

        // Randomized passes with random valid gaps and ignored re-starts.
        rnd_valid = 1'b1;
        for (int p = 0; p < 12; p++) begin
            logic [AW-1:0] n;
            logic [AW-1:0] b;
            n = AW'($urandom_range(1, 6));
            b = AW'($urandom);
            fill_rand(int'(n));
            start_pass(b, n, s);
            repeat ($urandom_range(0, 6)) begin
                @(posedge clk);
                #1;
            end
            base_addr = AW'($urandom);
            num_words = AW'($urandom);
            start = busy;
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_idle(400);
            @(posedge clk);
            #1;
        end
        rnd_valid = 1'b0;
        @(posedge clk);
        #1;

        check("end_writes_pending", DW'(exp_q.size()), DW'(0));
        check("end_done_pending", DW'(done_q.size()), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
